// File: rtl/dm_store_buffer_pkg.sv
// Shared constants, entry layout and byte-merge helper for the data-memory
// store buffer.
package dm_store_buffer_pkg;

    localparam int RAM_WORDS  = 4096;
    localparam int ADDR_W     = 12;
    localparam int SB_DEPTH   = 4;
    localparam int SB_ENTRY_W = ADDR_W + 36;

    localparam logic [3:0] BYTE0 = 4'b0001;
    localparam logic [3:0] BYTE1 = 4'b0010;
    localparam logic [3:0] BYTE2 = 4'b0100;
    localparam logic [3:0] BYTE3 = 4'b1000;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [31:0]       data;
        logic [3:0]        be;
    } sb_entry_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_w;
        if ((be & BYTE0) != 4'b0) res[7:0]   = new_w[7:0];
        if ((be & BYTE1) != 4'b0) res[15:8]  = new_w[15:8];
        if ((be & BYTE2) != 4'b0) res[23:16] = new_w[23:16];
        if ((be & BYTE3) != 4'b0) res[31:24] = new_w[31:24];
        return res;
    endfunction

endpackage

// File: rtl/dm_sb_fifo.sv
// Circular store-buffer FIFO with an age-ordered view of its entries
// (slot 0 = oldest) for load forwarding.
module dm_sb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DEPTH*W-1:0]       view_o,
    output logic [DEPTH-1:0]         valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i) mem_q[tail_q] <= wdata_i;
        end
    end

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_view
        localparam logic [PW-1:0] OFF = PW'(k);
        logic [PW-1:0] rd_ptr;
        assign rd_ptr              = head_q + OFF;
        assign view_o[k*W +: W]    = mem_q[rd_ptr];
        assign valid_o[k]          = (CW'(k) < count_q);
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Data RAM behind a posted store buffer with byte-wise load forwarding.
// Define DM_WRITE_TRACE_EN to print every accepted store.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic        m_data_ren,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        stall
);

    localparam int CW = $clog2(SB_DEPTH) + 1;

    logic [ADDR_W-1:0]          word_idx;
    logic                       st_req, push, pop, full, empty;
    logic [CW-1:0]              count;
    logic [SB_DEPTH*SB_ENTRY_W-1:0] view;
    logic [SB_DEPTH-1:0]        valid;
    sb_entry_t                  new_ent;
    sb_entry_t                  ent [SB_DEPTH];
    logic [31:0]                ram_q [RAM_WORDS];
    logic                       unused_bits;

    assign word_idx = m_data_addr[ADDR_W+1:2];
    assign st_req   = (m_data_byteen != 4'b0);
    assign push     = st_req & ~full;
    assign stall    = st_req & full;
    assign pop      = ~empty & ~m_data_ren;

    assign new_ent.idx  = word_idx;
    assign new_ent.data = m_data_wdata;
    assign new_ent.be   = m_data_byteen;

    dm_sb_fifo #(
        .DEPTH (SB_DEPTH),
        .W     (SB_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (new_ent),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count),
        .view_o  (view),
        .valid_o (valid)
    );

    always_comb begin
        for (int k = 0; k < SB_DEPTH; k++)
            ent[k] = view[k*SB_ENTRY_W +: SB_ENTRY_W];
    end

    // ent[0] is always the oldest entry, i.e. the one drained next
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
        end else if (pop) begin
            ram_q[ent[0].idx] <= byte_merge(ram_q[ent[0].idx],
                                            ent[0].data, ent[0].be);
        end
    end

    // Oldest-to-youngest overlay so the youngest store wins per lane
    always_comb begin
        m_data_rdata = ram_q[word_idx];
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (valid[k] && ent[k].idx == word_idx)
                m_data_rdata = byte_merge(m_data_rdata,
                                          ent[k].data, ent[k].be);
        end
    end

`ifdef DM_WRITE_TRACE_EN
    logic [31:0] trace_w;

    always_comb begin
        trace_w = byte_merge(m_data_rdata, m_data_wdata, m_data_byteen);
    end

    always_ff @(posedge clk) begin
        if (reset && push)
            $display("%d@%h: *%h <= %h", $time, m_inst_addr,
                     {m_data_addr[31:2], 2'b00}, trace_w);
    end
`endif

    assign unused_bits = ^{m_inst_addr, m_data_addr[31:ADDR_W+2],
                           m_data_addr[1:0], count};

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer.
module tb_dm_store_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic        m_data_ren;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        stall;

    int total = 0;
    int bad   = 0;

    dm_store_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_ren    (m_data_ren),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic ren);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        m_data_ren    = ren;
        m_inst_addr   = 32'h1000 + a;
        #1;
    endtask

    task automatic test_reset();
        drive(32'h10, 32'h0, 4'h0, 1'b0);
        total++;
        if (m_data_rdata !== 32'h0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_init rdata=%h stall=%b want 0/0",
                     m_data_rdata, stall);
        end
        reset = 1'b1;
        tick();
        drive(32'h10, 32'hDEAD0001, 4'hF, 1'b1); tick();
        drive(32'h14, 32'hDEAD0002, 4'hF, 1'b1); tick();
        drive(32'h18, 32'hDEAD0003, 4'hF, 1'b1); tick();
        drive(32'h10, 32'h0, 4'h0, 1'b1);
        total++;
        if (dut.u_fifo.count_q !== 3'd3 || m_data_rdata !== 32'hDEAD0001) begin
            bad++;
            $display("FAIL reset_pre count=%0d rdata=%h want 3/dead0001",
                     dut.u_fifo.count_q, m_data_rdata);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (dut.u_fifo.count_q !== 3'd0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid count=%0d stall=%b want 0/0",
                     dut.u_fifo.count_q, stall);
        end
        for (int i = 0; i < 3; i++) begin
            drive(32'h10 + 32'(4*i), 32'h0, 4'h0, 1'b1);
            total++;
            if (m_data_rdata !== 32'h0) begin
                bad++;
                $display("FAIL reset_lw%0d rdata=%h want 00000000",
                         i, m_data_rdata);
            end
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        drive(32'h10, 32'h12345678, 4'hF, 1'b1); tick();
        drive(32'h10, 32'h0, 4'h0, 1'b1);
        total++;
        if (m_data_rdata !== 32'h12345678 || dut.ram_q[4] !== 32'h0) begin
            bad++;
            $display("FAIL fwd rdata=%h ram=%h want 12345678/0",
                     m_data_rdata, dut.ram_q[4]);
        end
        drive(32'h4010, 32'h0, 4'h0, 1'b1);
        total++;
        if (m_data_rdata !== 32'h12345678) begin
            bad++;
            $display("FAIL fwd_wrap rdata=%h want 12345678", m_data_rdata);
        end
        drive(32'h10, 32'h0, 4'h0, 1'b0); tick();
        total++;
        if (dut.ram_q[4] !== 32'h12345678 || dut.u_fifo.count_q !== 3'd0) begin
            bad++;
            $display("FAIL fwd_drain ram=%h count=%0d want 12345678/0",
                     dut.ram_q[4], dut.u_fifo.count_q);
        end
    endtask

    task automatic test_partial();
        drive(32'h10, 32'h11223344, 4'hF, 1'b0); tick();
        drive(32'h10, 32'h0, 4'h0, 1'b0); tick();
        total++;
        if (dut.ram_q[4] !== 32'h11223344) begin
            bad++;
            $display("FAIL part_base ram=%h want 11223344", dut.ram_q[4]);
        end
        drive(32'h11, 32'h0000AB00, 4'b0010, 1'b1); tick();
        drive(32'h10, 32'h0, 4'h0, 1'b1);
        total++;
        if (m_data_rdata !== 32'h1122AB44 || dut.ram_q[4] !== 32'h11223344) begin
            bad++;
            $display("FAIL part_fwd rdata=%h ram=%h want 1122ab44/11223344",
                     m_data_rdata, dut.ram_q[4]);
        end
        drive(32'h10, 32'h0, 4'h0, 1'b0); tick();
        total++;
        if (dut.ram_q[4] !== 32'h1122AB44) begin
            bad++;
            $display("FAIL part_drain ram=%h want 1122ab44", dut.ram_q[4]);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(32'h20 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 1'b1);
            total++;
            if (stall !== 1'b0) begin
                bad++;
                $display("FAIL full_fill%0d stall=%b want 0", i, stall);
            end
            tick();
        end
        drive(32'h30, 32'hA4, 4'hF, 1'b1);
        total++;
        if (dut.u_fifo.count_q !== 3'd4 || stall !== 1'b1) begin
            bad++;
            $display("FAIL full_stall count=%0d stall=%b want 4/1",
                     dut.u_fifo.count_q, stall);
        end
        tick();
        total++;
        if (dut.u_fifo.count_q !== 3'd4 || stall !== 1'b1) begin
            bad++;
            $display("FAIL full_hold count=%0d stall=%b want 4/1",
                     dut.u_fifo.count_q, stall);
        end
        drive(32'h30, 32'hA4, 4'hF, 1'b0);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL full_drop stall=%b want 1", stall);
        end
        tick();
        total++;
        if (stall !== 1'b0 || dut.u_fifo.count_q !== 3'd3) begin
            bad++;
            $display("FAIL full_free stall=%b count=%0d want 0/3",
                     stall, dut.u_fifo.count_q);
        end
        drive(32'h30, 32'hA4, 4'hF, 1'b1); tick();
        drive(32'h30, 32'h0, 4'h0, 1'b1);
        total++;
        if (dut.u_fifo.count_q !== 3'd4 || m_data_rdata !== 32'hA4) begin
            bad++;
            $display("FAIL full_push count=%0d rdata=%h want 4/000000a4",
                     dut.u_fifo.count_q, m_data_rdata);
        end
        drive(32'h0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (dut.ram_q[8] !== 32'hA0 || dut.ram_q[11] !== 32'hA3 ||
            dut.ram_q[12] !== 32'hA4) begin
            bad++;
            $display("FAIL full_drain r8=%h r11=%h r12=%h want a0/a3/a4",
                     dut.ram_q[8], dut.ram_q[11], dut.ram_q[12]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r20 [5];
        exp_r20[0] = 32'h1; exp_r20[1] = 32'h1; exp_r20[2] = 32'h3;
        exp_r20[3] = 32'h4; exp_r20[4] = 32'h5;
        drive(32'h50, 32'h1, 4'hF, 1'b1); tick();
        drive(32'h54, 32'h2, 4'hF, 1'b1); tick();
        for (int i = 0; i < 5; i++) begin
            drive(32'h50, 32'h3 + 32'(i), 4'hF, 1'b0);
            total++;
            if (stall !== 1'b0) begin
                bad++;
                $display("FAIL b2b_stall%0d stall=%b want 0", i, stall);
            end
            tick();
            total++;
            if (dut.u_fifo.count_q !== 3'd2 || dut.ram_q[20] !== exp_r20[i]) begin
                bad++;
                $display("FAIL b2b_cyc%0d count=%0d r20=%h want 2/%h",
                         i, dut.u_fifo.count_q, dut.ram_q[20], exp_r20[i]);
            end
        end
        total++;
        if (dut.ram_q[21] !== 32'h2) begin
            bad++;
            $display("FAIL b2b_r21 r21=%h want 00000002", dut.ram_q[21]);
        end
        drive(32'h50, 32'h0, 4'h0, 1'b0); tick(); tick();
        total++;
        if (dut.ram_q[20] !== 32'h7 || dut.u_fifo.count_q !== 3'd0) begin
            bad++;
            $display("FAIL b2b_final r20=%h count=%0d want 7/0",
                     dut.ram_q[20], dut.u_fifo.count_q);
        end
    endtask

    task automatic test_youngest();
        drive(32'h40, 32'hAAAAAAAA, 4'hF, 1'b1); tick();
        drive(32'h40, 32'h000000BB, 4'b0001, 1'b1);
        total++;
        if (m_data_rdata !== 32'hAAAAAAAA) begin
            bad++;
            $display("FAIL young_excl rdata=%h want aaaaaaaa", m_data_rdata);
        end
        tick();
        drive(32'h40, 32'h0, 4'h0, 1'b1);
        total++;
        if (m_data_rdata !== 32'hAAAAAABB) begin
            bad++;
            $display("FAIL young_fwd rdata=%h want aaaaaabb", m_data_rdata);
        end
        drive(32'h40, 32'h0, 4'h0, 1'b0); tick(); tick();
        total++;
        if (dut.ram_q[16] !== 32'hAAAAAABB) begin
            bad++;
            $display("FAIL young_drain ram=%h want aaaaaabb", dut.ram_q[16]);
        end
    endtask

    initial begin
        reset         = 1'b0;
        m_data_addr   = '0;
        m_data_wdata  = '0;
        m_data_byteen = '0;
        m_data_ren    = 1'b0;
        m_inst_addr   = '0;
        #2;
        test_reset();
        test_forward();
        test_partial();
        test_full();
        test_back_to_back();
        test_youngest();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
